demux1to2_stream: RTL and testbench

Registered 1-to-2 stream demultiplexer: the inverse of the ALU datapath's 2:1 operand mux. Each accepted input beat carries a data word and a select bit, and is steered into one of two per-output FIFOs. Each output drains under its own valid/ready handshake. The block sits between the operand source and two independent ALU consumers, and also keeps per-output beat counters for debug.

---
 rtl/demux1to2_stream_if.sv | 28 ++
 rtl/demux1to2_stream.sv | 67 ++++++
 tb/tb_demux1to2_stream.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/demux1to2_stream_if.sv
// rtl/demux1to2_stream_if.sv - handshake bundle for the 1-to-2 stream demultiplexer
interface demux1to2_stream_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in;
  logic             sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in, sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0, out0_valid, out1, out1_valid, cnt0, cnt1
  );

  modport slave (
    input  in, sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0, out0_valid, out1, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux1to2_stream.sv
// rtl/demux1to2_stream.sv - registered 1-to-2 stream demux with per-output FIFOs and beat counters
module demux1to2_stream #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux1to2_stream_if.slave       bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [1:0]                  full;
  logic [1:0]                  valid;
  logic [1:0]                  push;
  logic [1:0]                  pop;
  logic [1:0]                  ready;
  logic [1:0][WIDTH-1:0]       head;
  logic [1:0][CNT_W-1:0]       beats;

  assign ready = {bus.out1_ready, bus.out0_ready};

  // in_ready looks only at the selected FIFO's fill state, never at the consumers
  assign bus.in_ready = !full[bus.sel];

  for (genvar n = 0; n < 2; n++) begin : g_fifo
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdptr;
    logic [PW-1:0]    wrptr;
    logic [PW:0]      count;
    logic [CNT_W-1:0] accepted;

    assign push[n]  = bus.in_valid && bus.in_ready && (bus.sel == 1'(n));
    assign pop[n]   = valid[n] && ready[n];
    assign full[n]  = (count == FULL_CNT);
    assign valid[n] = (count != '0);
    assign head[n]  = mem[rdptr];
    assign beats[n] = accepted;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        rdptr    <= '0;
        wrptr    <= '0;
        count    <= '0;
        accepted <= '0;
      end else begin
        if (push[n]) begin
          mem[wrptr] <= bus.in;
          wrptr      <= wrptr + 1'b1;
          accepted   <= accepted + 1'b1;
        end
        if (pop[n]) rdptr <= rdptr + 1'b1;
        if (push[n] && !pop[n])      count <= count + 1'b1;
        else if (!push[n] && pop[n]) count <= count - 1'b1;
      end
    end
  end

  assign bus.out0       = head[0];
  assign bus.out1       = head[1];
  assign bus.out0_valid = valid[0];
  assign bus.out1_valid = valid[1];
  assign bus.cnt0       = beats[0];
  assign bus.cnt1       = beats[1];
endmodule

// File: tb/tb_demux1to2_stream.sv
// tb/tb_demux1to2_stream.sv - directed table-driven bench for demux1to2_stream
module tb_demux1to2_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_applied = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  demux1to2_stream_if #(.WIDTH(4), .CNT_W(8)) bus ();

  demux1to2_stream #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [3:0] din;
    logic       sel;
    logic       vld;
    logic       r0;
    logic       r1;
    logic       e_ir;
    logic       e_v0;
    logic [3:0] e_d0;
    logic       e_v1;
    logic [3:0] e_d1;
    logic [7:0] e_c0;
    logic [7:0] e_c1;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(int din, int sel, int vld, int r0, int r1, int ir,
                              int v0, int d0, int v1, int d1, int c0, int c1);
    vec_t v;
    v.din = 4'(din);  v.sel = 1'(sel);  v.vld = 1'(vld);
    v.r0 = 1'(r0);    v.r1 = 1'(r1);    v.e_ir = 1'(ir);
    v.e_v0 = 1'(v0);  v.e_d0 = 4'(d0);  v.e_v1 = 1'(v1);
    v.e_d1 = 4'(d1);  v.e_c0 = 8'(c0);  v.e_c1 = 8'(c1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] din, input logic s, input logic v,
                       input logic r0, input logic r1);
    bus.in = din; bus.sel = s; bus.in_valid = v;
    bus.out0_ready = r0; bus.out1_ready = r1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] p_in;
  logic       p_sel;
  logic       p_vld;
  logic [3:0] s_in;
  logic       s_sel;

  initial begin
    // pre-edge expectations: outputs reflect state left by earlier vectors
    tbl[0]  = mk(4'h3, 0, 1, 0, 0, 1, 0, 0,    0, 0,    0, 0);
    tbl[1]  = mk(4'hC, 1, 1, 0, 0, 1, 1, 4'h3, 0, 0,    1, 0);
    tbl[2]  = mk(4'h0, 0, 0, 1, 1, 1, 1, 4'h3, 1, 4'hC, 1, 1);
    tbl[3]  = mk(4'h1, 0, 1, 0, 0, 1, 0, 0,    0, 0,    1, 1);
    tbl[4]  = mk(4'h2, 0, 1, 0, 0, 1, 1, 4'h1, 0, 0,    2, 1);
    tbl[5]  = mk(4'h3, 0, 1, 0, 0, 0, 1, 4'h1, 0, 0,    3, 1);
    tbl[6]  = mk(4'h7, 1, 1, 0, 0, 1, 1, 4'h1, 0, 0,    3, 1);
    tbl[7]  = mk(4'h0, 0, 0, 1, 0, 0, 1, 4'h1, 1, 4'h7, 3, 2);
    tbl[8]  = mk(4'h0, 0, 0, 1, 0, 1, 1, 4'h2, 1, 4'h7, 3, 2);
    tbl[9]  = mk(4'h5, 0, 1, 0, 0, 1, 0, 0,    1, 4'h7, 3, 2);
    tbl[10] = mk(4'h6, 0, 1, 0, 0, 1, 1, 4'h5, 1, 4'h7, 4, 2);
    tbl[11] = mk(4'h9, 0, 1, 1, 0, 0, 1, 4'h5, 1, 4'h7, 5, 2);
    tbl[12] = mk(4'h9, 0, 1, 1, 0, 1, 1, 4'h6, 1, 4'h7, 5, 2);
    tbl[13] = mk(4'h0, 0, 0, 0, 1, 1, 1, 4'h9, 1, 4'h7, 6, 2);
    tbl[14] = mk(4'h0, 1, 0, 1, 0, 1, 1, 4'h9, 0, 0,    6, 2);
    tbl[15] = mk(4'h0, 0, 0, 0, 0, 1, 0, 0,    0, 0,    6, 2);

    // reset held with a beat pending
    drive(4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_v0", 32'(bus.out0_valid), 0);
    chk("rst_v1", 32'(bus.out1_valid), 0);
    chk("rst_out0", 32'(bus.out0), 0);
    chk("rst_out1", 32'(bus.out1), 0);
    chk("rst_cnt0", 32'(bus.cnt0), 0);
    chk("rst_cnt1", 32'(bus.cnt1), 0);
    chk("rst_ir", 32'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); #1;
    chk("post_rst_v0", 32'(bus.out0_valid), 1);
    chk("post_rst_d0", 32'(bus.out0), 32'h A);
    chk("post_rst_cnt0", 32'(bus.cnt0), 1);

    // directed table
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].din, tbl[i].sel, tbl[i].vld, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("v%0d_ir", i), 32'(bus.in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("v%0d_v0", i), 32'(bus.out0_valid), 32'(tbl[i].e_v0));
      chk($sformatf("v%0d_v1", i), 32'(bus.out1_valid), 32'(tbl[i].e_v1));
      if (tbl[i].e_v0) chk($sformatf("v%0d_d0", i), 32'(bus.out0), 32'(tbl[i].e_d0));
      if (tbl[i].e_v1) chk($sformatf("v%0d_d1", i), 32'(bus.out1), 32'(tbl[i].e_d1));
      chk($sformatf("v%0d_c0", i), 32'(bus.cnt0), 32'(tbl[i].e_c0));
      chk($sformatf("v%0d_c1", i), 32'(bus.cnt1), 32'(tbl[i].e_c1));
      tick();
    end

    // streaming: each beat must show up on its port exactly one cycle later
    do_reset();
    p_vld = 1'b0; p_in = '0; p_sel = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s_in  = 4'($urandom_range(0, 15));
      s_sel = (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      if (i == 0) s_sel = 1'b0;
      drive(s_in, s_sel, (i < 16), 1'b1, 1'b1);
      #1;
      if (i < 16) chk($sformatf("st%0d_ir", i), 32'(bus.in_ready), 1);
      chk($sformatf("st%0d_v0", i), 32'(bus.out0_valid), 32'(p_vld && !p_sel));
      chk($sformatf("st%0d_v1", i), 32'(bus.out1_valid), 32'(p_vld && p_sel));
      if (p_vld && !p_sel) chk($sformatf("st%0d_d0", i), 32'(bus.out0), 32'(p_in));
      if (p_vld &&  p_sel) chk($sformatf("st%0d_d1", i), 32'(bus.out1), 32'(p_in));
      p_vld = (i < 16); p_in = s_in; p_sel = s_sel;
      tick();
    end
    #1;
    chk("st_sum", 32'(int'(bus.cnt0) + int'(bus.cnt1)), 16);

    // counter wrap on output 1
    do_reset();
    drive(4'h5, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 255; i++) tick();
    #1;
    chk("wrap_255", 32'(bus.cnt1), 255);
    tick();
    drive(4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("wrap_cnt1", 32'(bus.cnt1), 0);
    chk("wrap_cnt0", 32'(bus.cnt0), 0);

    // asynchronous reset with both FIFOs full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(4'(i + 1), 1'(i / 2), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mid_v0", 32'(bus.out0_valid), 1);
    chk("mid_v1", 32'(bus.out1_valid), 1);
    chk("mid_ir0", 32'(bus.in_ready), 0);
    chk("mid_c1", 32'(bus.cnt1), 2);
    rst_n = 1'b0;
    #1;
    chk("async_v0", 32'(bus.out0_valid), 0);
    chk("async_v1", 32'(bus.out1_valid), 0);
    chk("async_c0", 32'(bus.cnt0), 0);
    chk("async_ir", 32'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); #1;
    chk("after_v0", 32'(bus.out0_valid), 0);
    chk("after_v1", 32'(bus.out1_valid), 0);
    chk("after_c1", 32'(bus.cnt1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end
endmodule
